// File: rtl/priority_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// priority_round_robin_arbiter
//
// Shares one resource among 8 requesters using a rotating priority pointer.
// A grant is held until the holder asserts holder_release, drops its request,
// or has held the grant for MAX_HOLD consecutive cycles. Every grant is
// followed by exactly one GAP cycle. The holder index is also shown on a
// 7-segment digit, so the display outputs are registered together with grant.
//
// Parameters:
//   MAX_HOLD        maximum consecutive cycles of one grant (1..255)
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   req[7:0]        level-sensitive request lines, bit i = requester i
//   holder_release  holder finished with the resource (the "release" line;
//                   renamed because release is a reserved word). Only looked
//                   at while a grant is held.
//   grant[7:0]      registered one-hot grant, zero when nobody holds it
//   busy            high while in GRANT
//   timeout         one-cycle pulse in the GAP after a forced release
//   segments[6:0]   {g,f,e,d,c,b,a} digit of the holder index, 0 when idle
//   none            high when no grant is held (decimal point)
// -----------------------------------------------------------------------------
module priority_round_robin_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       holder_release,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [6:0] segments,
  output logic       none
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] holder_reg, holder_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] grant_next;
  logic       timeout_next;
  logic [6:0] segments_next;
  logic       none_next;

  logic [7:0] rot_req;
  logic       win_found;
  logic [2:0] win_idx;
  logic       hold_hit;
  logic       release_cond;

  // Digit pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] digit(input logic [2:0] idx);
    logic [6:0] seg;
    case (idx)
      3'd0:    seg = 7'b0111111;
      3'd1:    seg = 7'b0000110;
      3'd2:    seg = 7'b1011011;
      3'd3:    seg = 7'b1001111;
      3'd4:    seg = 7'b1100110;
      3'd5:    seg = 7'b1101101;
      3'd6:    seg = 7'b1111101;
      default: seg = 7'b0000111;
    endcase
    return seg;
  endfunction

  // Rotate the request vector so that position j holds requester (ptr - j)
  // mod 8; the lowest set position is then the winner of the downward search.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg - 3'(gi)];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (!win_found && rot_req[j]) begin
        win_found = 1'b1;
        win_idx   = ptr_reg - 3'(j);
      end
    end
  end

  assign hold_hit     = (hold_cnt_reg == HOLD_LIMIT);
  assign release_cond = holder_release || !req[holder_reg] || hold_hit;
  assign busy         = (state_reg == GRANT);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    holder_next   = holder_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant;
    timeout_next  = 1'b0;
    segments_next = segments;
    none_next     = none;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next    = GRANT;
          holder_next   = win_idx;
          hold_cnt_next = 8'd1;
          grant_next    = 8'd1 << win_idx;
          segments_next = digit(win_idx);
          none_next     = 1'b0;
        end
      end

      GRANT: begin
        if (release_cond) begin
          state_next    = GAP;
          grant_next    = 8'd0;
          segments_next = 7'd0;
          none_next     = 1'b1;
          ptr_next      = holder_reg - 3'd1;
          // A voluntary release or a dropped request outranks the limit.
          timeout_next  = hold_hit && !holder_release && req[holder_reg];
        end else if (hold_cnt_reg != 8'hFF) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end

      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next    = IDLE;
        grant_next    = 8'd0;
        segments_next = 7'd0;
        none_next     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd7;
      holder_reg   <= 3'd0;
      hold_cnt_reg <= 8'd0;
      grant        <= 8'd0;
      timeout      <= 1'b0;
      segments     <= 7'd0;
      none         <= 1'b1;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      holder_reg   <= holder_next;
      hold_cnt_reg <= hold_cnt_next;
      grant        <= grant_next;
      timeout      <= timeout_next;
      segments     <= segments_next;
      none         <= none_next;
    end
  end

endmodule

// File: doc/priority_round_robin_arbiter.md
# priority_round_robin_arbiter

Sequential arbiter that shares one resource among 8 requesters using rotating priority. Each grant is held until the holder releases it, drops its request, or hits a hold-time limit. The index of the current grant holder drives a 7-segment display (segments abcdefg plus a `none` indicator), so the arbiter sits directly in front of the board's display pins. With the rotation pointer at its reset value, arbitration matches the fixed bit-7-highest priority encoder.

## Interface
- `MAX_HOLD`, default 8: maximum number of consecutive cycles one grant is held. Legal range 1..255.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input 8: request lines, bit i = requester i. Level-sensitive.
- `release` input 1: holder finished. Sampled only in GRANT.
- `grant` output 8: one-hot grant, registered. All zero when no grant is held.
- `busy` output 1: high in GRANT.
- `timeout` output 1: one-cycle pulse in the GAP cycle that follows a forced release.
- `segments` output 7: {g,f,e,d,c,b,a} digit for the holder index, registered. 0 when no grant is held.
- `none` output 1: high when no grant is held (decimal point).

## Operation
- States: IDLE, GRANT, GAP.
- Reset (async, `rst_n`=0) sets:
  - state=IDLE, ptr=7, hold_cnt=0
  - grant=0, busy=0, timeout=0, segments=0, none=1
- Priority search order runs from ptr downward, mod 8: ptr, ptr-1, …, ptr-7. The first set `req` bit wins.
- IDLE:
  - If `req`≠0, load grant=onehot(k) and hold_cnt=1, set segments=digit(k) and none=0, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the release condition is any of:
  - `release`=1
  - `req[k]`=0
  - hold_cnt==`MAX_HOLD`
- On a release condition:
  - Clear grant, set segments=0 and none=1.
  - Set ptr=(k-1) mod 8.
  - Set `timeout`=1 only if hold_cnt==`MAX_HOLD` and neither `release` nor `req[k]`=0 caused it.
  - Go to GAP.
- Without a release condition, increment hold_cnt (8-bit, saturating, never wraps).
- GAP: exactly one cycle with grant=0. `timeout` clears at exit. Always go to IDLE; no arbitration happens in GAP.
- Digits (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
- Invariants:
  - `grant` is one-hot or zero.
  - `none`==(grant==0).
  - `segments` is always consistent with `grant` in the same cycle.
- Simultaneous events: if `release`=1, `req[k]`=0 and hold_cnt==`MAX_HOLD` coincide, the voluntary release takes precedence and `timeout` stays 0.
- Requests arriving during GRANT or GAP are not lost; `req` is level-held and is re-evaluated in IDLE.

## Timing
- Request to grant: `req` high before edge N while in IDLE gives `grant` valid after edge N (1 cycle).
- Grant length:
  - Minimum is 1 cycle: `release` sampled at the first GRANT edge.
  - Maximum is `MAX_HOLD` cycles.
- Release to next grant: the release condition is sampled at edge M.
  - M: enter GAP.
  - M+1: enter IDLE.
  - M+2: next grant.
  - The resource is therefore idle for 2 cycles between grants.
- Outputs change only on clock edges, except the asynchronous reset assert.
- Reset mid-GRANT:
  - All outputs take their reset values immediately.
  - ptr returns to 7, so the next arbitration is fixed-priority again.

## Test plan
- Reset: `rst_n`=0 with req=0xFF
  - Required: grant=0x00, busy=0, segments=0000000, none=1, timeout=0.
- Fixed priority after reset: req=0x81
  - Edge 1: grant=0x80, segments=0000111, none=0.
  - Pulse `release`, keep req=0x81. Two cycles later: grant=0x01, segments=0000110.
- Rotation fairness: req=0xFF held, `release` pulsed once per grant.
  - Holder order is 7,6,5,4,3,2,1,0,7 with a 2-cycle gap between grants.
- Timeout: `MAX_HOLD`=4, req=0x24, `release` never asserted.
  - grant=0x20 for exactly 4 cycles.
  - Then timeout=1 for one cycle, grant=0x00.
  - Then grant=0x04 for 4 cycles.
- Request drop mid-grant: grant=0x08 active, drop req[3].
  - Next edge: grant=0x00, timeout=0.
  - Then ptr=2, so with req=0x0C the next grant is 0x04.
- Async reset mid-GRANT: assert `rst_n`=0 between edges while grant=0x10.
  - grant=0, none=1 immediately, before the next edge.
  - After release of reset with req=0x11: grant=0x10.
